data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data memory responder.
//   WORD_W / word_t : data and address width (64 bits)
//   size_e          : access-size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_D
//   state_e         : responder FSM states
//   req_t           : request fields captured on the accept edge
//   is_misaligned() : alignment check from the low three address bits
package data_mem_responder_pkg;

  localparam int WORD_W = 64;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic  write;
    size_e size;
    logic  sgn;
    word_t addr;
    word_t wdata;
  } req_t;

  // An access of size n must start on a 2^n byte boundary.
  function automatic logic is_misaligned(input logic [2:0] off, input size_e size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for one 64-bit doubleword.
//   size      : access size (SIZE_B..SIZE_D)
//   sgn       : sign-extend loaded data
//   byte_off  : byte offset of the access inside the doubleword
//   wdata     : right-aligned store data
//   old_dw    : current doubleword contents
//   merged_dw : old_dw with the addressed bytes replaced by store data
//   load_data : addressed bytes, right-aligned and zero/sign extended
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [2:0]        byte_off,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] old_dw,
  output logic [WORD_W-1:0] merged_dw,
  output logic [WORD_W-1:0] load_data
);

  logic [7:0]  byte_mask;
  logic [63:0] wdata_sh;
  logic [63:0] rdata_sh;

  // NOTE: every output gets a value on every path so no latch is inferred.
  always_comb begin
    case (size_e'(size))
      SIZE_B:  byte_mask = 8'h01 << byte_off;
      SIZE_H:  byte_mask = 8'h03 << byte_off;
      SIZE_W:  byte_mask = 8'h0F << byte_off;
      default: byte_mask = 8'hFF;
    endcase

    // Little-endian: byte k of the doubleword lives at address offset k.
    wdata_sh = wdata << {byte_off, 3'b000};
    for (int i = 0; i < 8; i++) begin
      merged_dw[8*i +: 8] = byte_mask[i] ? wdata_sh[8*i +: 8] : old_dw[8*i +: 8];
    end

    rdata_sh = old_dw >> {byte_off, 3'b000};
    case (size_e'(size))
      SIZE_B:  load_data = {{56{sgn & rdata_sh[7]}},  rdata_sh[7:0]};
      SIZE_H:  load_data = {{48{sgn & rdata_sh[15]}}, rdata_sh[15:0]};
      SIZE_W:  load_data = {{32{sgn & rdata_sh[31]}}, rdata_sh[31:0]};
      default: load_data = rdata_sh;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Doubleword-organised data memory behind a valid/ready request/response
// handshake with a fixed, parameterised access latency.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_write, req_size, req_signed, req_addr, req_wdata : request fields
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_error  : load data (0 for stores/errors), error flag
//   busy                  : FSM not in IDLE
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_DW = 256,
  parameter int LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy
);

  localparam int         IDX_W    = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
  localparam word_t      LIMIT    = word_t'(DEPTH_DW) * 64'd8;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  state_e           state;
  logic [3:0]       cnt;
  req_t             req_q;
  word_t            mem [DEPTH_DW];

  logic [IDX_W-1:0] idx;
  word_t            old_dw;
  word_t            merged_dw;
  word_t            load_data;
  logic             access_err;
  logic             do_write;

  assign idx    = req_q.addr[3 +: IDX_W];
  assign old_dw = mem[idx];

  // Full-width range compare: high address bits never wrap onto the array.
  assign access_err = is_misaligned(req_q.addr[2:0], req_q.size) || (req_q.addr >= LIMIT);
  assign do_write   = (state == ST_WAIT) && (cnt == 4'd0) && req_q.write && !access_err;

  mem_lane_align u_lane (
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .byte_off  (req_q.addr[2:0]),
    .wdata     (req_q.wdata),
    .old_dw    (old_dw),
    .merged_dw (merged_dw),
    .load_data (load_data)
  );

  // Handshake outputs are gated by reset so they read as idle while reset is held.
  assign req_ready = (state == ST_IDLE) && !reset;
  assign rsp_valid = (state == ST_RESP) && !reset;
  assign busy      = (state != ST_IDLE) && !reset;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q <= '{write: req_write, size: size_e'(req_size), sgn: req_signed,
                       addr: req_addr, wdata: req_wdata};
            cnt   <= LAT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_error <= access_err;
            rsp_rdata <= (access_err || req_q.write) ? '0 : load_data;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents survive reset, and a
  // reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem[idx] <= merged_dw;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: instance a uses LATENCY=2, instance b uses
// LATENCY=0 with rsp_ready tied high.
module tb_data_mem_responder;

  localparam int LAT_A = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error, busy;
  logic [63:0] rsp_rdata;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0, req_signed_b = 1'b0, rsp_ready_b = 1'b1;
  logic [1:0]  req_size_b = 2'd3;
  logic [63:0] req_addr_b = '0, req_wdata_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_error_b, busy_b;
  logic [63:0] rsp_rdata_b;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_DW(256), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy)
  );

  data_mem_responder #(.DEPTH_DW(256), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_size(req_size_b), .req_signed(req_signed_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance a: accept, check latency and response,
  // then complete the response. Request inputs are scrambled after accept.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] ad, input logic [63:0] wd,
                        input logic [63:0] exp_data, input logic exp_err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_signed = ~sg;
    req_addr = ~ad; req_wdata = ~wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 20);
    check({tag, " latency"}, 64'(n), 64'(LAT_A + 1));
    check({tag, " rdata"}, rsp_rdata, exp_data);
    check({tag, " error"}, 64'(rsp_error), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] hold_val;
    logic        acc;
    int          n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst rsp_rdata", rsp_rdata, 64'd0);
    check("rst rsp_error", 64'(rsp_error), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    check("post-rst req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Doubleword store and load.
    do_req("st D 0x10", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 64'd0, 1'b0);
    do_req("ld D 0x10", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0);

    // Byte 0x13 is the top byte of the word at 0x10 (bytes 88 77 66 55 -> 88 77 66 AA).
    do_req("st B 0x13", 1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFFFFFFFFFFFFAA, 64'd0, 1'b0);
    do_req("ld W s 0x10", 1'b0, 2'd2, 1'b1, 64'h10, 64'd0, 64'hFFFFFFFFAA667788, 1'b0);
    do_req("ld W u 0x10", 1'b0, 2'd2, 1'b0, 64'h10, 64'd0, 64'h00000000AA667788, 1'b0);
    do_req("ld H s 0x12", 1'b0, 2'd1, 1'b1, 64'h12, 64'd0, 64'hFFFFFFFFFFFFAA66, 1'b0);
    do_req("ld B s 0x11", 1'b0, 2'd0, 1'b1, 64'h11, 64'd0, 64'h0000000000000077, 1'b0);
    do_req("ld D 0x10 after B", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h11223344AA667788, 1'b0);

    // Errors and range boundaries.
    do_req("ld H 0x11 misaligned", 1'b0, 2'd1, 1'b0, 64'h11, 64'd0, 64'd0, 1'b1);
    do_req("ld D 0x800 range", 1'b0, 2'd3, 1'b0, 64'h800, 64'd0, 64'd0, 1'b1);
    do_req("st D 0x0", 1'b1, 2'd3, 1'b0, 64'h0, 64'h0, 64'd0, 1'b0);
    do_req("st D 0x800 range", 1'b1, 2'd3, 1'b0, 64'h800, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b1);
    do_req("st D high addr", 1'b1, 2'd3, 1'b0, 64'h1000000000000000, 64'hDEADBEEFDEADBEEF, 64'd0, 1'b1);
    do_req("ld D 0x0 unchanged", 1'b0, 2'd3, 1'b0, 64'h0, 64'd0, 64'd0, 1'b0);
    do_req("st D 0x7F8 last", 1'b1, 2'd3, 1'b0, 64'h7F8, 64'h5A5A00FF00FF5A5A, 64'd0, 1'b0);
    do_req("ld D 0x7F8 last", 1'b0, 2'd3, 1'b0, 64'h7F8, 64'd0, 64'h5A5A00FF00FF5A5A, 1'b0);

    // Response held while rsp_ready is low and request inputs toggle.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold rsp_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = i[0]; req_size = i[1:0];
      req_addr = 64'(i * 8); req_wdata = 64'(i) * 64'h0101010101010101;
      @(posedge clk); #1;
      check("hold rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold rdata", rsp_rdata, 64'h11223344AA667788);
      check("hold error", 64'(rsp_error), 64'd0);
      check("hold req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("release rsp_valid", 64'(rsp_valid), 64'd0);
    check("release busy", 64'(busy), 64'd0);
    check("release req_ready", 64'(req_ready), 64'd1);

    // Reset during WAIT aborts a pending store.
    do_req("st D 0x20", 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 64'h20; req_wdata = 64'hFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort req_ready", 64'(req_ready), 64'd0);
    check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort rdata", rsp_rdata, 64'd0);
    check("abort error", 64'(rsp_error), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    do_req("ld D 0x20 after abort", 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0);

    // LATENCY=0 instance: back-to-back requests, store then repeated loads.
    hold_val = 64'hCAFEF00D12345678;
    req_valid_b = 1'b1; req_write_b = 1'b1; req_size_b = 2'd3;
    req_addr_b = 64'h8; req_wdata_b = hold_val;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      acc = req_valid_b & req_ready_b;
      @(posedge clk); #1;
      if (k == 0) req_write_b = 1'b0;
      check($sformatf("b accept k=%0d", k), 64'(acc), 64'((k % 3) == 0));
      check($sformatf("b rsp_valid k=%0d", k), 64'(rsp_valid_b), 64'((k % 3) == 1));
      if ((k % 3) == 1) begin
        check($sformatf("b rdata k=%0d", k), rsp_rdata_b, (k == 1) ? 64'd0 : hold_val);
      end
    end
    req_valid_b = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
